// File: rtl/encoder_pkg.sv
// Shared types and constants for the request-vector encoder.
package encoder_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        ZERO  = 2'd2
    } state_e;

    localparam int DEFAULT_WIDTH = 8;

    // Number of bits needed to hold an index into an n-bit vector.
    function automatic int clog2_w(input int n);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < n) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/encoder_8to3_drain_ffs.sv
// Combinational find-first-set over WIDTH bits.
// Scan direction: lowest bit first by default; highest bit first when
// ENCODER_MSB_FIRST_EN is defined.
module ffs_encoder
    import encoder_pkg::*;
#(
    parameter  int WIDTH  = DEFAULT_WIDTH,
    localparam int CODE_W = clog2_w(WIDTH)
) (
    input  logic [WIDTH-1:0]  vec_i,
    output logic [CODE_W-1:0] index_o,
    output logic [WIDTH-1:0]  onehot_rem_o
);

    // Priority scan: the last matching assignment wins, so the loop runs
    // from the lowest-priority end toward the highest-priority end.
    always_comb begin
        index_o = '0;
`ifdef ENCODER_MSB_FIRST_EN
        for (int i = 0; i < WIDTH; i++) begin
            if (vec_i[i]) begin
                index_o = CODE_W'(i);
            end
        end
`else
        for (int i = WIDTH - 1; i >= 0; i--) begin
            if (vec_i[i]) begin
                index_o = CODE_W'(i);
            end
        end
`endif
        onehot_rem_o          = vec_i;
        onehot_rem_o[index_o] = 1'b0;
    end

endmodule

// File: rtl/encoder_8to3_drain.sv
// Multi-hot request vector to binary code stream, one code per beat.
// Optional macro ENCODER_MSB_FIRST_EN flips the emission order to descending.
module encoder_8to3_drain
    import encoder_pkg::*;
#(
    parameter  int WIDTH  = DEFAULT_WIDTH,
    localparam int CODE_W = clog2_w(WIDTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [WIDTH-1:0]  in_vec,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [CODE_W-1:0] out_code,
    output logic              out_valid,
    input  logic              out_ready,
    output logic              out_last,
    output logic              out_zero,
    output logic [CODE_W:0]   out_idx
);

    state_e              state_q, state_d;
    logic [WIDTH-1:0]    pending_q, pending_d;
    logic [CODE_W:0]     idx_q, idx_d;

    logic [CODE_W-1:0]   ffsIndex;
    logic [WIDTH-1:0]    ffsRem;
    logic                lastBit;

    ffs_encoder #(.WIDTH(WIDTH)) u_ffs (
        .vec_i        (pending_q),
        .index_o      (ffsIndex),
        .onehot_rem_o (ffsRem)
    );

    assign lastBit = (ffsRem == '0);

    // Next-state and output decode; outputs depend only on registered state.
    always_comb begin
        state_d   = state_q;
        pending_d = pending_q;
        idx_d     = idx_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_code  = '0;
        out_last  = 1'b0;
        out_zero  = 1'b0;
        out_idx   = '0;
        unique case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    idx_d = '0;
                    if (in_vec != '0) begin
                        pending_d = in_vec;
                        state_d   = DRAIN;
                    end else begin
                        state_d   = ZERO;
                    end
                end
            end
            DRAIN: begin
                out_valid = 1'b1;
                out_code  = ffsIndex;
                out_last  = lastBit;
                out_idx   = idx_q;
                if (out_ready) begin
                    if (lastBit) begin
                        pending_d = '0;
                        idx_d     = '0;
                        state_d   = IDLE;
                    end else begin
                        pending_d = ffsRem;
                        idx_d     = idx_q + 1'b1;
                    end
                end
            end
            ZERO: begin
                out_valid = 1'b1;
                out_last  = 1'b1;
                out_zero  = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State, pending-bit and beat-counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pending_q <= '0;
            idx_q     <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            idx_q     <= idx_d;
        end
    end

endmodule

// File: tb/tb_encoder_8to3_drain.sv
// Scoreboard bench for encoder_8to3_drain (WIDTH = 8).
module tb_encoder_8to3_drain;

    typedef struct packed {
        logic [2:0] code;
        logic       last;
        logic       zero;
        logic [3:0] idx;
    } beat_t;

    logic       clk;
    logic       rst;
    logic [7:0] in_vec;
    logic       in_valid;
    logic       in_ready;
    logic [2:0] out_code;
    logic       out_valid;
    logic       out_ready;
    logic       out_last;
    logic       out_zero;
    logic [3:0] out_idx;

    int    checks;
    int    fails;
    beat_t sb[$];

    encoder_8to3_drain #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_vec    (in_vec),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_code  (out_code),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last),
        .out_zero  (out_zero),
        .out_idx   (out_idx)
    );

    // Free-running clock, 10 ns period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: expected beats for one accepted vector.
    task automatic push_vector(input logic [7:0] v);
        int order[$];
        beat_t b;
        if (v == 8'h00) begin
            b.code = 3'd0; b.last = 1'b1; b.zero = 1'b1; b.idx = 4'd0;
            sb.push_back(b);
        end else begin
`ifdef ENCODER_MSB_FIRST_EN
            for (int i = 7; i >= 0; i--) if (v[i]) order.push_back(i);
`else
            for (int i = 0; i < 8; i++) if (v[i]) order.push_back(i);
`endif
            for (int k = 0; k < order.size(); k++) begin
                b.code = 3'(order[k]);
                b.last = (k == order.size() - 1);
                b.zero = 1'b0;
                b.idx  = 4'(k);
                sb.push_back(b);
            end
        end
    endtask

    // Present one vector in IDLE for a single accept edge.
    task automatic send(input logic [7:0] v);
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL send_ready: in_ready=%b expected 1", in_ready);
        end
        in_vec   = v;
        in_valid = 1'b1;
        push_vector(v);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        checks++;
        if ({out_valid, in_ready, out_code, out_last, out_zero, out_idx} !== {1'b0, 1'b1, 3'd0, 1'b0, 1'b0, 4'd0}) begin
            fails++;
            $display("[TB] FAIL reset_state: valid=%b ready=%b code=%0d last=%b zero=%b idx=%0d expected 0 1 0 0 0 0",
                     out_valid, in_ready, out_code, out_last, out_zero, out_idx);
        end
    endtask

    task automatic test_zero();
        out_ready = 1'b1;
        send(8'h00);
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin
            checks++;
            if (!out_valid || {out_code, out_last, out_zero, out_idx} !== sb[0]) begin
                fails++;
                $display("[TB] FAIL zero_beat: valid=%b got %h expected %h", out_valid, {out_code, out_last, out_zero, out_idx}, sb[0]);
            end
            void'(sb.pop_front());
            @(negedge clk);
        end
        checks++;
        if (sb.size() != 0 || in_ready !== 1'b1 || out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL zero_after: left=%0d in_ready=%b out_valid=%b expected 0 1 0", sb.size(), in_ready, out_valid);
        end
    endtask

    task automatic test_sparse();
        out_ready = 1'b1;
        send(8'b1010_0100);
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin
            checks++;
            if (!out_valid || in_ready || {out_code, out_last, out_zero, out_idx} !== sb[0]) begin
                fails++;
                $display("[TB] FAIL sparse_beat: valid=%b in_ready=%b got %h expected %h",
                         out_valid, in_ready, {out_code, out_last, out_zero, out_idx}, sb[0]);
            end
            void'(sb.pop_front());
            @(negedge clk);
        end
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL sparse_done: left=%0d out_valid=%b expected 0 0", sb.size(), out_valid);
        end
    endtask

    task automatic test_stall();
        out_ready = 1'b1;
        send(8'hFF);
        for (int c = 0; c < 40 && sb.size() > 0; c++) begin
            out_ready = (c % 2 == 0);
            checks++;
            if (!out_valid || in_ready || {out_code, out_last, out_zero, out_idx} !== sb[0]) begin
                fails++;
                $display("[TB] FAIL stall_beat: cyc=%0d valid=%b in_ready=%b got %h expected %h",
                         c, out_valid, in_ready, {out_code, out_last, out_zero, out_idx}, sb[0]);
            end
            if (out_ready) void'(sb.pop_front());
            @(negedge clk);
        end
        out_ready = 1'b1;
        checks++;
        if (sb.size() != 0 || out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL stall_done: left=%0d out_valid=%b in_ready=%b", sb.size(), out_valid, in_ready);
        end
    endtask

    task automatic test_back_to_back();
        out_ready = 1'b1;
        @(negedge clk);
        in_vec   = 8'h01;
        in_valid = 1'b1;
        push_vector(8'h01);
        @(negedge clk);
        in_vec = 8'h80;
        checks++;
        if (!out_valid || in_ready || {out_code, out_last, out_zero, out_idx} !== sb[0]) begin
            fails++;
            $display("[TB] FAIL b2b_first: valid=%b in_ready=%b got %h expected %h",
                     out_valid, in_ready, {out_code, out_last, out_zero, out_idx}, sb[0]);
        end
        void'(sb.pop_front());
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
            fails++;
            $display("[TB] FAIL b2b_bubble: out_valid=%b in_ready=%b expected 0 1", out_valid, in_ready);
        end
        push_vector(8'h80);
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (!out_valid || {out_code, out_last, out_zero, out_idx} !== sb[0]) begin
            fails++;
            $display("[TB] FAIL b2b_second: valid=%b got %h expected %h",
                     out_valid, {out_code, out_last, out_zero, out_idx}, sb[0]);
        end
        void'(sb.pop_front());
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL b2b_done: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_reset_mid();
        out_ready = 1'b1;
        send(8'hF0);
        for (int c = 0; c < 2; c++) begin
            checks++;
            if (!out_valid || {out_code, out_last, out_zero, out_idx} !== sb[0]) begin
                fails++;
                $display("[TB] FAIL midrst_beat: valid=%b got %h expected %h",
                         out_valid, {out_code, out_last, out_zero, out_idx}, sb[0]);
            end
            void'(sb.pop_front());
            @(negedge clk);
        end
        rst       = 1'b1;
        out_ready = 1'b0;
        sb.delete();
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || out_idx !== 4'd0) begin
            fails++;
            $display("[TB] FAIL midrst_state: out_valid=%b in_ready=%b idx=%0d expected 0 1 0", out_valid, in_ready, out_idx);
        end
        send(8'h08);
        for (int c = 0; c < 20 && sb.size() > 0; c++) begin
            checks++;
            if (!out_valid || {out_code, out_last, out_zero, out_idx} !== sb[0]) begin
                fails++;
                $display("[TB] FAIL midrst_new: valid=%b got %h expected %h",
                         out_valid, {out_code, out_last, out_zero, out_idx}, sb[0]);
            end
            void'(sb.pop_front());
            @(negedge clk);
        end
        checks++;
        if (out_valid !== 1'b0) begin
            fails++;
            $display("[TB] FAIL midrst_done: out_valid=%b expected 0", out_valid);
        end
    endtask

    task automatic test_walk();
        out_ready = 1'b1;
        for (int p = 0; p < 8; p++) begin
            logic [7:0] v;
            v = 8'h01 << p;
            send(v);
            for (int c = 0; c < 20 && sb.size() > 0; c++) begin
                checks++;
                if (!out_valid || {out_code, out_last, out_zero, out_idx} !== sb[0]) begin
                    fails++;
                    $display("[TB] FAIL walk_bit%0d: valid=%b got %h expected %h",
                             p, out_valid, {out_code, out_last, out_zero, out_idx}, sb[0]);
                end
                void'(sb.pop_front());
                @(negedge clk);
            end
            checks++;
            if (sb.size() != 0 || out_valid !== 1'b0) begin
                fails++;
                $display("[TB] FAIL walk_done%0d: left=%0d out_valid=%b", p, sb.size(), out_valid);
            end
        end
    endtask

    // Scenario sequence and summary.
    initial begin
        checks    = 0;
        fails     = 0;
        rst       = 1'b1;
        in_vec    = 8'h00;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        test_reset();
        test_zero();
        test_sparse();
        test_stall();
        test_back_to_back();
        test_reset_mid();
        test_walk();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

    // Global watchdog so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "[TB] watchdog expired");
    end

endmodule

// File: doc/encoder_8to3_drain.md
Name: encoder_8to3_drain

Overview:
- Sequential counterpart to the team's 3-to-8 decoder. Accepts a WIDTH-bit request vector over a valid/ready handshake.
- Emits the binary index of every set bit, one code per beat, lowest index first. This turns multi-hot vectors into a code stream that the decoder consumes.
- Sits between request-collection logic and any decoder-driven select path.

Parameters:
- WIDTH, 8, input vector width; must be a power of two and at least 2.
- CODE_W, $clog2(WIDTH), code width; derived localparam, not overridable.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- in_vec  input  WIDTH  request vector; sampled on accept.
- in_valid  input  1  upstream holds in_vec valid.
- in_ready  output  1  block can accept; high only in IDLE.
- out_code  output  CODE_W  index of the current set bit.
- out_valid  output  1  out_code, out_last, out_zero and out_idx are valid.
- out_ready  input  1  downstream accepts the current beat.
- out_last  output  1  final beat for this vector.
- out_zero  output  1  accepted vector was all-zero; the beat carries no index.
- out_idx  output  CODE_W+1  beat number within the current vector, starting at 0.

Behaviour:
- Clock and reset: one clock, clk; synchronous active-high reset, rst.
- All outputs are driven from registers or state only; there is no combinational path from in_* or out_ready to outputs, except in_ready, which decodes state.
- Reset values: state=IDLE, pending=0, out_valid=0, out_code=0, out_last=0, out_zero=0, out_idx=0, in_ready=1.
- States are IDLE, DRAIN and ZERO.
- IDLE:
  - in_ready=1, out_valid=0.
  - Accept happens on in_valid&&in_ready at edge N.
  - If in_vec≠0: pending<=in_vec, out_idx<=0, go to DRAIN.
  - If in_vec=0: go to ZERO.
  - First out_valid appears in cycle N+1, so latency is 1 cycle.
- DRAIN:
  - out_valid=1, out_code=find-first-set(pending) from bit 0 upward.
  - out_last=1 when pending has exactly one bit set.
  - On out_valid&&out_ready: clear that bit in pending and increment out_idx.
  - If out_last, go to IDLE instead.
  - While out_ready=0, all outputs hold stable.
- ZERO:
  - Emits one beat with out_valid=1, out_zero=1, out_last=1, out_code=0, out_idx=0.
  - On out_ready, go to IDLE.
- Throughput:
  - One code per cycle while out_ready=1.
  - One bubble cycle in IDLE between vectors; no accept overlaps the last beat.
- Boundary conditions:
  - all-ones vector gives WIDTH beats, out_idx 0..WIDTH-1, out_last on the beat with out_idx=WIDTH-1.
  - A single set bit gives one beat with out_last=1.
  - in_valid held high in DRAIN or ZERO is ignored and not consumed; upstream keeps it pending.
- rst asserted mid-drain: at the next edge, go to IDLE and clear pending. The in-flight vector is dropped and no out_last is generated.
- out_ready asserted while out_valid=0 has no effect.

Optional Feature:
- Macro: ENCODER_MSB_FIRST_EN.
- Defined: find-first-set scans from bit WIDTH-1 downward, so codes are emitted in descending order. out_last is still "one bit left".
- Undefined: ascending order as specified above.
- Handshake, latency and out_idx behaviour are identical in both builds.

Decomposition:
- Package encoder_pkg:
  - state enum {IDLE, DRAIN, ZERO};
  - code-width function clog2_w;
  - default WIDTH constant.
- Sub-module ffs_encoder: combinational find-first-set over WIDTH bits.
  - Outputs index and onehot_rem (vector with the found bit cleared).
  - The macro selects the scan direction inside this sub-module.

Test Plan:
- Reset, then in_vec=8'b0000_0000 with in_valid → one beat: out_zero=1, out_last=1, out_code=0, out_idx=0; in_ready=1 on the following cycle.
- in_vec=8'b1010_0100 with out_ready=1 → codes 2,5,7 on consecutive cycles; out_idx 0,1,2; out_last only on code 7. With ENCODER_MSB_FIRST_EN: codes 7,5,2.
- in_vec=8'hFF with out_ready toggling 1,0,1,0… → 8 beats, codes 0..7; outputs stable during stalls; out_last on code 7; in_ready=0 throughout.
- Back-to-back: in_valid held high with 8'h01 then 8'h80 → code 0 (last), one IDLE cycle, then code 7 (last); the second vector is accepted only in IDLE.
- rst pulsed after 2 beats of 8'hF0 → next cycle out_valid=0, in_ready=1; a new vector 8'h08 then yields a single code 3 with out_idx=0.
- Single bit walked through positions 0..7 → each gives one beat, out_code equal to the bit position, out_last=1. This mirrors the 3-to-8 decoder round-trip check.
